// File: rtl/led_seq_ctrl.sv
// LED bank controller: a 16-byte register window (DATA, MODE, PERIOD, STATUS)
// plus a pattern engine that drives the 24 LED pins with a static pattern,
// a blinking pattern or a rotating pattern paced by a programmable prescaler.
module led_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000,
  parameter logic [31:0] DEF_PERIOD = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [23:0] led,
  output logic        tick
);

  // Engine states; the encoding is visible to software in STATUS[31:30].
  localparam logic [1:0] ST_STATIC    = 2'd0;
  localparam logic [1:0] ST_BLINK_ON  = 2'd1;
  localparam logic [1:0] ST_BLINK_OFF = 2'd2;
  localparam logic [1:0] ST_ROT       = 2'd3;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_MODE   = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic        hit_s;
  logic [1:0]  off_s;
  logic        wr_data_s;
  logic        wr_mode_s;
  logic        wr_per_s;
  logic [31:0] eff_per_s;
  logic        roll_s;

  logic [23:0] data_r;
  logic [2:0]  mode_r;
  logic [31:0] period_r;
  logic [31:0] cnt_r;
  logic [1:0]  state_r;
  logic [23:0] led_r;
  logic        tick_r;

  logic [1:0]  state_nx_s;
  logic [23:0] led_nx_s;
  logic [31:0] cnt_nx_s;
  logic        tick_nx_s;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic        unused_addr_s;

  // Map a MODE field onto the engine state it starts; reserved mode 3 is static.
  function automatic logic [1:0] mode_to_state(input logic [1:0] m);
    logic [1:0] s;
    case (m)
      2'd1:    s = ST_BLINK_ON;
      2'd2:    s = ST_ROT;
      default: s = ST_STATIC;
    endcase
    return s;
  endfunction

  assign hit_s         = (addr[31:4] == BASE_ADDR[31:4]);
  assign off_s         = addr[3:2];
  assign wr_data_s     = we && hit_s && (off_s == OFF_DATA);
  assign wr_mode_s     = we && hit_s && (off_s == OFF_MODE);
  assign wr_per_s      = we && hit_s && (off_s == OFF_PERIOD);
  assign unused_addr_s = ^addr[1:0];

  // A zero period behaves like a period of one (rollover every cycle).
  assign eff_per_s = (period_r == 32'd0) ? 32'd1 : period_r;
  assign roll_s    = (state_r != ST_STATIC) && (cnt_r == (eff_per_s - 32'd1));

  // Read mux: combinational so software sees register changes without delay.
  always_comb begin
    rdata = 32'h0000_0000;
    if (hit_s) begin
      case (off_s)
        OFF_DATA:   rdata = {8'h00, data_r};
        OFF_MODE:   rdata = {29'd0, mode_r};
        OFF_PERIOD: rdata = period_r;
        OFF_STATUS: rdata = {state_r, 6'd0, led_r};
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Engine next state: any CPU register write takes priority over a rollover,
  // which then loses both its LED change and its tick.
  always_comb begin
    state_nx_s = state_r;
    led_nx_s   = led_r;
    tick_nx_s  = 1'b0;
    if (state_r == ST_STATIC) begin
      cnt_nx_s = 32'd0;
    end else if (roll_s) begin
      cnt_nx_s = 32'd0;
    end else begin
      cnt_nx_s = cnt_r + 32'd1;
    end

    if (wr_mode_s) begin
      state_nx_s = mode_to_state(wdata[1:0]);
      cnt_nx_s   = 32'd0;
      led_nx_s   = data_r;
    end else if (wr_per_s) begin
      cnt_nx_s = 32'd0;
      if ((state_r == ST_STATIC) || (state_r == ST_BLINK_ON)) begin
        led_nx_s = data_r;
      end else begin
        led_nx_s = led_r;
      end
    end else if (wr_data_s) begin
      case (state_r)
        ST_STATIC:    led_nx_s = wdata[23:0];
        ST_BLINK_ON:  led_nx_s = wdata[23:0];
        ST_BLINK_OFF: led_nx_s = led_r;
        ST_ROT: begin
          led_nx_s = wdata[23:0];
          cnt_nx_s = 32'd0;
        end
        default:      led_nx_s = led_r;
      endcase
    end else begin
      case (state_r)
        ST_STATIC: led_nx_s = data_r;
        ST_BLINK_ON: begin
          if (roll_s) begin
            state_nx_s = ST_BLINK_OFF;
            led_nx_s   = 24'd0;
            tick_nx_s  = 1'b1;
          end else begin
            led_nx_s = data_r;
          end
        end
        ST_BLINK_OFF: begin
          if (roll_s) begin
            state_nx_s = ST_BLINK_ON;
            led_nx_s   = data_r;
            tick_nx_s  = 1'b1;
          end else begin
            led_nx_s = led_r;
          end
        end
        ST_ROT: begin
          if (roll_s) begin
            tick_nx_s = 1'b1;
            if (mode_r[2]) begin
              led_nx_s = {led_r[0], led_r[23:1]};
            end else begin
              led_nx_s = {led_r[22:0], led_r[23]};
            end
          end else begin
            led_nx_s = led_r;
          end
        end
        default: begin
          state_nx_s = ST_STATIC;
          led_nx_s   = 24'd0;
        end
      endcase
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r   <= 24'd0;
      mode_r   <= 3'd0;
      period_r <= DEF_PERIOD;
    end else begin
      if (wr_data_s) data_r   <= wdata[23:0];
      if (wr_mode_s) mode_r   <= wdata[2:0];
      if (wr_per_s)  period_r <= wdata;
    end
  end

  // Engine state, prescaler and registered LED/tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_STATIC;
      cnt_r   <= 32'd0;
      led_r   <= 24'd0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      led_r   <= led_nx_s;
      tick_r  <= tick_nx_s;
    end
  end

  assign led  = led_r;
  assign tick = tick_r;

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Memory-mapped controller that owns the 24-bit board LED bank behind the CPU bus bridge.
- Arbitrates between CPU store writes and an autonomous pattern engine: static, blink or rotate.
- The engine uses a programmable prescaler, so software sets a pattern once and the hardware animates it.
- Sits on the bridge peripheral port next to the LED output register; its led output drives the pins directly.

Parameters:
- BASE_ADDR, 32'hFFFF_F000, base address of the 16-byte register window; match on addr[31:4].
- DEF_PERIOD, 32'd50_000_000, PERIOD register reset value in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  bus write strobe, one cycle per store.
- addr  in  32  byte address from the bridge.
- wdata  in  32  bus write data.
- rdata  out  32  read data; combinational from registers.
- led  out  24  LED drive, registered.
- tick  out  1  one-cycle pulse at each prescaler rollover; for debug/IRQ.

Behaviour:
- Decode: hit = (addr[31:4] == BASE_ADDR[31:4]). Offset addr[3:2]: 0 DATA, 1 MODE, 2 PERIOD, 3 STATUS (read-only). Writes to STATUS or with hit=0 are ignored.
- Registers:
  - DATA[23:0]: pattern.
  - MODE[2:0]: [1:0] mode (0 static, 1 blink, 2 rotate, 3 reserved = static); [2] dir (0 left, 1 right).
  - PERIOD[31:0].
  - STATUS = {state[1:0], 6'b0, led[23:0]}.
- Reset values: DATA=0, MODE=0, PERIOD=DEF_PERIOD, prescaler cnt=0, state=STATIC, led=0, tick=0. rdata reflects these immediately.
- rdata: selected register when hit and offset valid, else 32'h0. Unused upper bits read 0.
- Prescaler:
  - cnt increments each cycle in BLINK_ON, BLINK_OFF and ROT.
  - Effective period P = (PERIOD==0) ? 1 : PERIOD.
  - When cnt == P-1: cnt <= 0 and tick <= 1 for the next cycle.
  - In STATIC, cnt is held at 0 and tick stays 0.
- FSM states: STATIC, BLINK_ON, BLINK_OFF, ROT.
  - STATIC: led <= DATA every cycle.
  - Write to MODE: cnt <= 0 at the same edge. Next state: mode 1 -> BLINK_ON, mode 2 -> ROT, mode 0/3 -> STATIC.
  - BLINK_ON: led = DATA. On rollover -> BLINK_OFF, led <= 0.
  - BLINK_OFF: on rollover -> BLINK_ON, led <= DATA.
  - ROT: on entry, led <= DATA. On each rollover, led rotates by 1.
    - dir=0: led <= {led[22:0], led[23]}.
    - dir=1: led <= {led[0], led[23:1]}.
- Update latency: a DATA write appears on led at the next edge in STATIC and BLINK_ON (latency 1 cycle).
- DATA write in BLINK_OFF: stored only; led stays 0 until the next ON phase.
- DATA write in ROT: led <= new DATA and cnt <= 0 (rotation restarts from the new pattern).
- PERIOD write: takes effect immediately; cnt <= 0.
- Simultaneous events: a CPU write at the same edge as a rollover wins. The rollover's led change is dropped, and no tick is emitted for that rollover.
- PERIOD=0 or 1: rollover every cycle; blink toggles each cycle, rotate steps each cycle.
- Counter wrap: cnt is 32 bits. If PERIOD is lowered below the current cnt, the PERIOD write's cnt reset prevents an overrun.
- Reset mid-operation: all state returns to reset values asynchronously; led=0 within the same cycle as rst assertion.

Test Plan:
- Reset, then write DATA=0x00A5A5 (offset 0x0) -> led=0x00A5A5 one cycle after the write; STATUS read = 0x00_00A5A5.
- PERIOD=4, DATA=0x0000FF, MODE=1 -> led alternates 0x0000FF and 0x000000 every 4 cycles; tick pulses every 4th cycle.
- PERIOD=2, DATA=0x800001, MODE=2 (left) -> led sequence 0x800001, 0x000003, 0x000006, stepping every 2 cycles. MODE=6 (right) from 0x800001 -> 0xC00000.
- Rotate mode; write DATA=0x000010 on the exact rollover edge -> led=0x000010 with no rotation that cycle, tick not asserted, next step after 2 more cycles.
- PERIOD=0 in blink mode -> led toggles every cycle. Write to addr 0xFFFF_E000 -> no register changes, rdata=0.
- Assert rst mid-rotation -> led=0 immediately, MODE read=0, PERIOD read=DEF_PERIOD after release.
